// File: rtl/reflet_unaligned_access_unit.sv
// Byte-granular CPU load/store front end for a word-wide RAM without byte enables; handles accesses that straddle two words.
// Latency (1-cycle ack): aligned load 3 cycles accept->done, straddling store 6; each RAM wait cycle adds one.
// Backpressure: ram_req is held with stable address/data until ram_ack; cpu_req is ignored while busy.
module reflet_unaligned_access_unit #(
    parameter int word_size = 32,
    parameter int addr_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [addr_size-1:0] cpu_addr,
    input  logic                 cpu_write_en,
    input  logic [word_size-1:0] cpu_data_out,
    input  logic [3:0]           size_used,
    output logic [word_size-1:0] cpu_data_in,
    output logic                 cpu_done,
    output logic                 cpu_busy,
    output logic [addr_size-1:0] ram_addr,
    output logic [word_size-1:0] ram_data_out,
    output logic                 ram_write_en,
    output logic                 ram_req,
    input  logic [word_size-1:0] ram_data_in,
    input  logic                 ram_ack
);

    localparam int WB   = word_size / 8;
    localparam int OFFW = $clog2(WB);
    localparam int DW   = 2 * word_size;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t               r_state;
    logic [OFFW-1:0]      r_off;
    logic [OFFW:0]        r_n;
    logic                 r_we;
    logic                 r_cross;
    logic [addr_size-1:0] r_lo;
    logic [addr_size-1:0] r_hi;
    logic [word_size-1:0] r_wdata;
    logic [word_size-1:0] r_lo_word;
    logic [word_size-1:0] r_hi_word;
    logic [word_size-1:0] r_cpu_data_in;
    logic                 r_cpu_done;
    logic [addr_size-1:0] r_ram_addr;
    logic [word_size-1:0] r_ram_data_out;
    logic                 r_ram_we;
    logic                 r_ram_req;

    // Request decode from the live CPU inputs; only used in the accept cycle.
    logic [3:0]           w_k;
    logic [OFFW:0]        w_req_n;
    logic [OFFW-1:0]      w_req_off;
    logic [addr_size-1:0] w_req_lo;
    logic                 w_req_cross;
    logic                 w_req_full;

    assign w_k       = size_used - 4'd1;
    assign w_req_off = cpu_addr[OFFW-1:0];
    assign w_req_lo  = {cpu_addr[addr_size-1:OFFW], {OFFW{1'b0}}};

    // Access size in bytes: 0 means a full word, larger sizes clamp to the word.
    always_comb begin
        w_req_n = (OFFW+1)'(WB);
        if (size_used != 4'd0 && int'(w_k) < OFFW) begin
            w_req_n = (OFFW+1)'(1) << w_k;
        end
    end

    assign w_req_cross = ((OFFW+2)'(w_req_off) + (OFFW+2)'(w_req_n)) > (OFFW+2)'(WB);
    assign w_req_full  = (w_req_off == '0) && (w_req_n == (OFFW+1)'(WB));

    // Datapath over the two-word window {hi, lo}. The word arriving in the
    // current ack cycle is taken straight from the RAM so it can be used on
    // the same edge that captures it.
    logic [word_size-1:0] w_lo_src;
    logic [word_size-1:0] w_hi_src;
    logic [OFFW+2:0]      w_sh;
    logic [OFFW+3:0]      w_nbits;
    logic [DW-1:0]        w_nmask;
    logic [DW-1:0]        w_smask;
    logic [DW-1:0]        w_merged;
    logic [word_size-1:0] w_load;

    assign w_lo_src = (r_state == RD_LO) ? ram_data_in : r_lo_word;
    assign w_hi_src = (r_state == RD_HI) ? ram_data_in : r_hi_word;
    assign w_sh     = {r_off, 3'b000};
    assign w_nbits  = {r_n, 3'b000};
    assign w_nmask  = (DW'(1) << w_nbits) - DW'(1);
    assign w_smask  = w_nmask << w_sh;
    assign w_merged = ({w_hi_src, w_lo_src} & ~w_smask) | ((DW'(r_wdata) << w_sh) & w_smask);
    assign w_load   = word_size'(({w_hi_src, w_lo_src} >> w_sh) & w_nmask);

    // Sequencer: read the touched words, merge for partial stores, write back, then pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_off          <= '0;
            r_n            <= '0;
            r_we           <= 1'b0;
            r_cross        <= 1'b0;
            r_lo           <= '0;
            r_hi           <= '0;
            r_wdata        <= '0;
            r_lo_word      <= '0;
            r_hi_word      <= '0;
            r_cpu_data_in  <= '0;
            r_cpu_done     <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_data_out <= '0;
            r_ram_we       <= 1'b0;
            r_ram_req      <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_off      <= w_req_off;
                        r_n        <= w_req_n;
                        r_we       <= cpu_write_en;
                        r_cross    <= w_req_cross;
                        r_lo       <= w_req_lo;
                        r_hi       <= w_req_lo + addr_size'(WB);
                        r_wdata    <= cpu_data_out;
                        r_ram_req  <= 1'b1;
                        r_ram_addr <= w_req_lo;
                        if (cpu_write_en && w_req_full) begin
                            r_state        <= WR_LO;
                            r_ram_we       <= 1'b1;
                            r_ram_data_out <= cpu_data_out;
                        end else begin
                            r_state  <= RD_LO;
                            r_ram_we <= 1'b0;
                        end
                    end
                end
                RD_LO: begin
                    if (ram_ack) begin
                        r_lo_word <= ram_data_in;
                        if (r_cross) begin
                            r_state    <= RD_HI;
                            r_ram_addr <= r_hi;
                        end else if (r_we) begin
                            r_state        <= WR_LO;
                            r_ram_we       <= 1'b1;
                            r_ram_data_out <= w_merged[word_size-1:0];
                        end else begin
                            r_state       <= DONE;
                            r_ram_req     <= 1'b0;
                            r_cpu_data_in <= w_load;
                            r_cpu_done    <= 1'b1;
                        end
                    end
                end
                RD_HI: begin
                    if (ram_ack) begin
                        r_hi_word <= ram_data_in;
                        if (r_we) begin
                            r_state        <= WR_LO;
                            r_ram_addr     <= r_lo;
                            r_ram_we       <= 1'b1;
                            r_ram_data_out <= w_merged[word_size-1:0];
                        end else begin
                            r_state       <= DONE;
                            r_ram_req     <= 1'b0;
                            r_cpu_data_in <= w_load;
                            r_cpu_done    <= 1'b1;
                        end
                    end
                end
                WR_LO: begin
                    if (ram_ack) begin
                        if (r_cross) begin
                            r_state        <= WR_HI;
                            r_ram_addr     <= r_hi;
                            r_ram_data_out <= w_merged[DW-1:word_size];
                        end else begin
                            r_state    <= DONE;
                            r_ram_req  <= 1'b0;
                            r_ram_we   <= 1'b0;
                            r_cpu_done <= 1'b1;
                        end
                    end
                end
                WR_HI: begin
                    if (ram_ack) begin
                        r_state    <= DONE;
                        r_ram_req  <= 1'b0;
                        r_ram_we   <= 1'b0;
                        r_cpu_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_data_in  = r_cpu_data_in;
    assign cpu_done     = r_cpu_done;
    assign cpu_busy     = (r_state != IDLE);
    assign ram_addr     = r_ram_addr;
    assign ram_data_out = r_ram_data_out;
    assign ram_write_en = r_ram_we;
    assign ram_req      = r_ram_req;

endmodule

// File: tb/tb_reflet_unaligned_access_unit.sv
// Directed bench for reflet_unaligned_access_unit: 32/32 instance plus an 8-bit-address instance for wrap.
module tb_reflet_unaligned_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit address instance
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdat = '0;
    logic [3:0]  size_used = '0;
    logic [31:0] cpu_rdat, ram_addr, ram_wdat;
    logic        cpu_done, cpu_busy, ram_we, ram_req;
    logic [31:0] ram_rdat = '0;
    logic        ram_ack = 1'b0;

    // 8-bit address instance
    logic        b_req = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [3:0]  b_size = '0;
    logic [31:0] b_rdat, b_ram_wdat;
    logic [7:0]  b_ram_addr;
    logic        b_done, b_busy, b_ram_we, b_ram_req;
    logic [31:0] b_ram_rdat = '0;
    logic        b_ram_ack = 1'b0;

    reflet_unaligned_access_unit #(.word_size(32), .addr_size(32)) dut (
        .clk(clk), .reset(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_write_en(cpu_we), .cpu_data_out(cpu_wdat), .size_used(size_used),
        .cpu_data_in(cpu_rdat), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
        .ram_addr(ram_addr), .ram_data_out(ram_wdat), .ram_write_en(ram_we),
        .ram_req(ram_req), .ram_data_in(ram_rdat), .ram_ack(ram_ack)
    );

    reflet_unaligned_access_unit #(.word_size(32), .addr_size(8)) dut8 (
        .clk(clk), .reset(rst_n), .cpu_req(b_req), .cpu_addr(b_addr),
        .cpu_write_en(1'b0), .cpu_data_out(32'h0), .size_used(b_size),
        .cpu_data_in(b_rdat), .cpu_done(b_done), .cpu_busy(b_busy),
        .ram_addr(b_ram_addr), .ram_data_out(b_ram_wdat), .ram_write_en(b_ram_we),
        .ram_req(b_ram_req), .ram_data_in(b_ram_rdat), .ram_ack(b_ram_ack)
    );

    int errors = 0;
    int checks = 0;
    int stall = 0;

    logic [31:0] mem [0:63];
    logic [31:0] mem8 [0:63];
    logic        log_we [0:255];
    logic [31:0] log_addr [0:255];
    int          log_n = 0;
    int          done_cnt = 0;
    int          wait_cnt = 0;
    logic [7:0]  b_log_addr [0:255];
    int          b_log_n = 0;

    // RAM model A: ack after 'stall' wait cycles, read data presented with ack
    always @(negedge clk) begin
        if (ram_ack) wait_cnt = 0;
        ram_ack = 1'b0;
        if (!ram_req) wait_cnt = 0;
        else if (wait_cnt >= stall) begin
            ram_ack  = 1'b1;
            ram_rdat = mem[ram_addr[7:2]];
        end else wait_cnt++;
    end

    // RAM model A: commit writes and log completed accesses
    always @(posedge clk) begin
        if (ram_req && ram_ack) begin
            if (log_n < 256) begin
                log_we[log_n]   = ram_we;
                log_addr[log_n] = ram_addr;
            end
            log_n++;
            if (ram_we) mem[ram_addr[7:2]] = ram_wdat;
        end
        if (cpu_done) done_cnt++;
    end

    // RAM model B: zero-wait read-only
    always @(negedge clk) begin
        b_ram_ack = 1'b0;
        if (b_ram_req && !b_ram_we) begin
            b_ram_ack  = 1'b1;
            b_ram_rdat = mem8[b_ram_addr[7:2]];
        end
    end

    always @(posedge clk) begin
        if (b_ram_req && b_ram_ack) begin
            if (b_log_n < 256) b_log_addr[b_log_n] = b_ram_addr;
            b_log_n++;
        end
    end

    // Issue one access at a negedge; returns at the negedge where cpu_done is seen.
    task automatic run_a(input logic we, input logic [31:0] addr, input logic [3:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat, output bit ok);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; size_used = sz; cpu_wdat = wd;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); lat++;
            if (cpu_busy) break;
        end
        cpu_req = 1'b0; cpu_addr = 32'hDEADBEEF; cpu_wdat = 32'hA5A5A5A5; size_used = 4'hF; cpu_we = ~we;
        for (int i = 0; i < 200; i++) begin
            if (cpu_done) begin ok = 1'b1; break; end
            @(negedge clk); lat++;
        end
        rd = cpu_rdat;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({ram_req, cpu_done, cpu_busy, ram_we, ram_addr, ram_wdat, cpu_rdat} !== '0) begin
            errors++; $display("FAIL reset_outputs: got req=%b done=%b busy=%b we=%b addr=%h wd=%h rd=%h, want all 0",
                               ram_req, cpu_done, cpu_busy, ram_we, ram_addr, ram_wdat, cpu_rdat);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load_word();
        logic [31:0] rd; int lat; bit ok; int s; int d;
        @(negedge clk);
        stall = 0; s = log_n; d = done_cnt;
        run_a(1'b0, 32'h0, 4'd0, 32'h0, rd, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_done: got timeout, want cpu_done"); end
        checks++; if (rd !== 32'h76543210) begin errors++; $display("FAIL t1_data: got %h want 76543210", rd); end
        checks++; if (lat + 1 !== 3) begin errors++; $display("FAIL t1_latency: got %0d want 3", lat + 1); end
        checks++; if (log_n - s !== 1 || log_addr[s] !== 32'h0 || log_we[s] !== 1'b0) begin
            errors++; $display("FAIL t1_ram_ops: got %0d ops first addr %h we %b, want 1 read of 0", log_n - s, log_addr[s], log_we[s]);
        end
        @(negedge clk);
        checks++; if (cpu_done !== 1'b0 || cpu_busy !== 1'b0 || done_cnt - d !== 1) begin
            errors++; $display("FAIL t1_done_pulse: got done=%b busy=%b pulses=%0d want 0 0 1", cpu_done, cpu_busy, done_cnt - d);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] rd; int lat; bit ok; int s;
        @(negedge clk);
        s = log_n;
        run_a(1'b0, 32'h3, 4'd1, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'h00000076) begin errors++; $display("FAIL t2_data: got %h ok=%b want 00000076", rd, ok); end
        checks++; if (log_n - s !== 1 || log_addr[s] !== 32'h0) begin
            errors++; $display("FAIL t2_ram_ops: got %0d ops first addr %h, want 1 read of 0", log_n - s, log_addr[s]);
        end
    endtask

    task automatic test_load_cross();
        logic [31:0] rd; int lat; bit ok; int s;
        @(negedge clk);
        s = log_n;
        run_a(1'b0, 32'h3, 4'd3, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'hDCBA9876) begin errors++; $display("FAIL t3_data: got %h ok=%b want dcba9876", rd, ok); end
        checks++; if (log_n - s !== 2 || log_addr[s] !== 32'h0 || log_addr[s+1] !== 32'h4) begin
            errors++; $display("FAIL t3_ram_ops: got %0d ops %h %h, want reads 0 then 4", log_n - s, log_addr[s], log_addr[s+1]);
        end
    endtask

    task automatic test_stalls();
        logic [31:0] rd; int lat; bit ok;
        for (int st = 0; st <= 5; st++) begin
            @(negedge clk);
            stall = st;
            run_a(1'b0, 32'h3, 4'd3, 32'h0, rd, lat, ok);
            checks++; if (!ok || rd !== 32'hDCBA9876) begin
                errors++; $display("FAIL stall%0d_data: got %h ok=%b want dcba9876", st, rd, ok);
            end
        end
        stall = 0;
    endtask

    task automatic test_busy_hold();
        logic [31:0] rd; bit got; int s; int d;
        @(negedge clk);
        stall = 3; s = log_n; d = done_cnt; got = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; size_used = 4'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_busy) begin cpu_addr = 32'h4; cpu_we = 1'b1; size_used = 4'd1; end
            if (cpu_done) begin got = 1'b1; break; end
        end
        rd = cpu_rdat; cpu_req = 1'b0; cpu_we = 1'b0;
        checks++; if (!got || rd !== 32'h76543210) begin errors++; $display("FAIL busy_hold_data: got %h ok=%b want 76543210", rd, got); end
        @(negedge clk); @(negedge clk);
        checks++; if (log_n - s !== 1 || done_cnt - d !== 1 || cpu_busy !== 1'b0) begin
            errors++; $display("FAIL busy_hold_single: got ops=%0d pulses=%0d busy=%b want 1 1 0", log_n - s, done_cnt - d, cpu_busy);
        end
        stall = 0;
    endtask

    task automatic test_store_cross();
        logic [31:0] rd; int lat; bit ok; int s;
        @(negedge clk);
        s = log_n;
        run_a(1'b1, 32'h3, 4'd2, 32'h000088FF, rd, lat, ok);
        checks++; if (!ok || lat + 1 !== 6) begin errors++; $display("FAIL t4_latency: got %0d ok=%b want 6", lat + 1, ok); end
        checks++; if (mem[0] !== 32'hFF543210 || mem[1] !== 32'hFEDCBA88) begin
            errors++; $display("FAIL t4_mem: got %h %h want ff543210 fedcba88", mem[0], mem[1]);
        end
        checks++; if (log_n - s !== 4 || {log_we[s], log_we[s+1], log_we[s+2], log_we[s+3]} !== 4'b0011 ||
                      log_addr[s] !== 32'h0 || log_addr[s+1] !== 32'h4 || log_addr[s+2] !== 32'h0 || log_addr[s+3] !== 32'h4) begin
            errors++; $display("FAIL t4_ram_ops: got %0d ops we=%b%b%b%b, want R0 R4 W0 W4", log_n - s,
                               log_we[s], log_we[s+1], log_we[s+2], log_we[s+3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; bit ok;
        @(negedge clk);
        run_a(1'b0, 32'h0, 4'd0, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'hFF543210) begin errors++; $display("FAIL b2b_first: got %h ok=%b want ff543210", rd, ok); end
        run_a(1'b0, 32'h5, 4'd2, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'h0000DCBA || lat !== 3) begin
            errors++; $display("FAIL b2b_second: got %h lat=%0d ok=%b want 0000dcba lat 3", rd, lat, ok);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; int lat; bit ok; int s; int d; bit found;
        @(negedge clk);
        stall = 2; s = log_n; d = done_cnt; found = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h3; size_used = 4'd2; cpu_wdat = 32'h000011EE;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_busy) cpu_req = 1'b0;
            if (ram_req && ram_we && ram_addr == 32'h4) begin found = 1'b1; break; end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL t6_reach_wr_hi: got timeout, want WR_HI request"); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({ram_req, cpu_done, cpu_busy, ram_we, ram_addr, ram_wdat, cpu_rdat} !== '0) begin
            errors++; $display("FAIL t6_async_reset: got req=%b busy=%b addr=%h, want all outputs 0", ram_req, cpu_busy, ram_addr);
        end
        @(negedge clk); @(negedge clk);
        checks++; if (done_cnt !== d || log_n - s !== 3) begin
            errors++; $display("FAIL t6_abandon: got pulses=%0d ops=%0d want 0 pulses 3 ops", done_cnt - d, log_n - s);
        end
        rst_n = 1'b1; stall = 0;
        run_a(1'b0, 32'h0, 4'd0, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'hEE543210) begin errors++; $display("FAIL t6_post_lo: got %h ok=%b want ee543210", rd, ok); end
        @(negedge clk);
        run_a(1'b0, 32'h4, 4'd0, 32'h0, rd, lat, ok);
        checks++; if (!ok || rd !== 32'hFEDCBA88) begin errors++; $display("FAIL t6_post_hi: got %h ok=%b want fedcba88", rd, ok); end
    endtask

    task automatic test_wrap();
        bit got;
        @(negedge clk);
        got = 1'b0;
        b_req = 1'b1; b_addr = 8'hFE; b_size = 4'd3;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_busy) begin b_req = 1'b0; b_addr = 8'h10; end
            if (b_done) begin got = 1'b1; break; end
        end
        b_req = 1'b0;
        checks++; if (!got || b_rdat !== 32'h3210AABB) begin errors++; $display("FAIL t5_data: got %h ok=%b want 3210aabb", b_rdat, got); end
        checks++; if (b_log_n !== 2 || b_log_addr[0] !== 8'hFC || b_log_addr[1] !== 8'h00) begin
            errors++; $display("FAIL t5_wrap_addr: got %0d ops %h %h want fc then 00", b_log_n, b_log_addr[0], b_log_addr[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; mem8[i] = 32'h0; end
        mem[0] = 32'h76543210; mem[1] = 32'hFEDCBA98;
        mem8[63] = 32'hAABBCCDD; mem8[0] = 32'h76543210;
        test_reset();
        test_load_word();
        test_load_byte();
        test_load_cross();
        test_stalls();
        test_busy_hold();
        test_store_cross();
        test_back_to_back();
        test_reset_midflight();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
